dm_mem_bus_arbiter: RTL and testbench
=====================================

# dm_mem_bus_arbiter

Two-master to one-slave arbiter between the core's debug-mode instruction-fetch and load/store ports and the single debug memory port of the debug memory block (halted/going/resuming flags, data words, program buffer, abstract command, debug ROM). It grants one request per cycle with round-robin fairness and address-window checking. It tracks the one-cycle read latency of the debug memory and returns each response to the master that issued it.

## Interface
Parameters:
- BusWidth, 32, address/data width
- DmBaseAddress, 32'h0, base of the 4 KiB debug window; addr[31:12] must equal DmBaseAddress[31:12]

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- i_req_i  in  1  fetch request; held with i_addr_i stable until i_gnt_o
- i_addr_i  in  BusWidth  fetch address
- i_flush_i  in  1  core redirect; discard fetch response due next cycle
- i_gnt_o  out  1  fetch request accepted this cycle
- i_rvalid_o  out  1  fetch response valid
- i_rdata_o  out  BusWidth  fetch data
- i_err_o  out  1  fetch response is an out-of-window error
- d_req_i, d_we_i  in  1  load/store request, write enable; held with d_addr_i, d_wdata_i and d_be_i until d_gnt_o
- d_addr_i, d_wdata_i  in  BusWidth  address, write data
- d_be_i  in  BusWidth/8  byte enables
- d_gnt_o, d_rvalid_o, d_err_o  out  1  grant, response valid, error
- d_rdata_o  out  BusWidth  load data; 0 for writes
- dm_req_o, dm_we_o  out  1  debug memory strobe, write enable
- dm_addr_o, dm_wdata_o  out  BusWidth  passthrough of the granted master
- dm_be_o  out  BusWidth/8  passthrough; fetch drives all ones
- dm_rdata_i  in  BusWidth  debug memory read data, valid the cycle after dm_req_o

## Operation
- Arbitration is combinational in the request cycle. Only one master requesting: that master is granted. Both requesting: grant the master not granted last (last_q, reset = data, so fetch wins first). last_q updates only on a grant.
- Window check: in_win = (addr[31:12] == DmBaseAddress[31:12]).
  - In-window grant: dm_req_o=1 and the granted master's signals are muxed onto dm_*.
  - Out-of-window grant: dm_req_o=0 and an error response is scheduled.
- No grant: dm_req_o=0, dm_we_o=0, and dm_addr_o, dm_wdata_o and dm_be_o are driven to 0.
- Response tracker registers, loaded on every grant and cleared otherwise:
  - resp_v_q: response pending
  - resp_src_q: 0 = fetch, 1 = data
  - resp_err_q
  - resp_we_q
- Response cycle (resp_v_q=1): assert {src}_rvalid_o.
  - rdata = 0 if resp_err_q or resp_we_q; otherwise dm_rdata_i.
  - err = resp_err_q.
  - The other master's rvalid/err/rdata are 0.
- Flush: i_flush_i=1 while resp_v_q=1 and resp_src_q=fetch suppresses i_rvalid_o that cycle. i_flush_i also suppresses any fetch grant in the same cycle, so the data port wins if it requests.
- Write acks: writes get rvalid with rdata 0. Out-of-window writes get rvalid with err=1.

## Timing
- Reset values: all outputs 0; resp_v_q=0; last_q=data.
- Grant latency 0 (gnt is combinational from req). Response latency is exactly 1 cycle after gnt.
- Throughput is one grant per cycle. A new grant may coincide with the previous response cycle.
- With both masters continuously requesting, grants alternate every cycle.
- Grant and response are not asserted to the same master in the same cycle unless back-to-back grants occurred.
- Reset asserted mid-transaction drops any pending response; no rvalid follows reset release.
- gnt outputs depend only on req, flush and last_q, never on addr. An error is still a granted transfer.

## Test plan
- Single fetch at DmBaseAddress+0x800, dm_rdata_i=32'h0ff0000f in the next cycle -> i_gnt_o same cycle, dm_be_o=4'hF, i_rvalid_o=1 and i_rdata_o=32'h0ff0000f one cycle later, d_rvalid_o=0.
- Store to 0x100 with d_be_i=4'h1 and d_wdata_i=0 -> dm_req_o=1, dm_we_o=1, dm_addr_o=0x100 same cycle; d_rvalid_o=1 and d_rdata_o=0 next cycle.
- Both masters held requesting for 4 cycles from reset -> grants fetch, data, fetch, data; responses are routed to the matching port one cycle after each grant.
- Load at DmBaseAddress+0x1000 -> d_gnt_o=1, dm_req_o=0; next cycle d_rvalid_o=1, d_err_o=1, d_rdata_o=0.
- Fetch granted, then i_flush_i=1 in the response cycle while d_req_i=1 -> i_rvalid_o=0, d_gnt_o=1, and the data response arrives the following cycle.
- rst_ni pulsed low in the cycle after a grant -> no rvalid on either port, outputs 0, and the next simultaneous request is granted to fetch.

Source files
------------

// File: rtl/dm_mem_bus_arbiter_if.sv
// Bus bundle between the core's debug-mode fetch/load-store ports, the
// arbiter and the debug memory port.
//   slave  : the arbiter's view (takes core requests, drives the memory port)
//   master : the environment's view (core ports plus the debug memory)
interface dm_mem_bus_arbiter_if #(
    parameter int unsigned BusWidth = 32
);
    localparam int unsigned BeWidth = BusWidth / 8;

    // fetch port
    logic                i_req_i;
    logic [BusWidth-1:0] i_addr_i;
    logic                i_flush_i;
    logic                i_gnt_o;
    logic                i_rvalid_o;
    logic [BusWidth-1:0] i_rdata_o;
    logic                i_err_o;

    // load/store port
    logic                d_req_i;
    logic                d_we_i;
    logic [BusWidth-1:0] d_addr_i;
    logic [BusWidth-1:0] d_wdata_i;
    logic [BeWidth-1:0]  d_be_i;
    logic                d_gnt_o;
    logic                d_rvalid_o;
    logic [BusWidth-1:0] d_rdata_o;
    logic                d_err_o;

    // debug memory port
    logic                dm_req_o;
    logic                dm_we_o;
    logic [BusWidth-1:0] dm_addr_o;
    logic [BusWidth-1:0] dm_wdata_o;
    logic [BeWidth-1:0]  dm_be_o;
    logic [BusWidth-1:0] dm_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i, i_flush_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, dm_be_o,
        input  dm_rdata_i
    );

    modport master (
        output i_req_i, i_addr_i, i_flush_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, dm_be_o,
        output dm_rdata_i
    );
endinterface

// File: rtl/dm_mem_bus_arbiter.sv
// Round-robin arbiter sharing the debug memory port between the debug-mode
// fetch and load/store ports. Grants are combinational; a one-entry tracker
// routes the single-cycle-latency response (or a window error) back.
module dm_mem_bus_arbiter #(
    parameter int unsigned         BusWidth      = 32,
    parameter logic [BusWidth-1:0] DmBaseAddress = '0
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    dm_mem_bus_arbiter_if.slave  bus
);
    localparam int unsigned BeWidth = BusWidth / 8;
    localparam int unsigned WinLsb  = 12;

    typedef enum logic {
        SrcFetch = 1'b0,
        SrcData  = 1'b1
    } src_e;

    src_e last_q;
    logic resp_v_q;
    src_e resp_src_q;
    logic resp_err_q;
    logic resp_we_q;

    logic                fetch_req;
    logic                gnt_i;
    logic                gnt_d;
    logic                any_gnt;
    logic [BusWidth-1:0] sel_addr;
    logic                in_win;
    logic                dm_req;
    logic [BusWidth-1:0] resp_rdata;
    logic                i_rvalid;
    logic                d_rvalid;

    // Arbitration and window check for the current request cycle
    always_comb begin
        fetch_req = bus.i_req_i & ~bus.i_flush_i;
        gnt_i     = fetch_req   & (~bus.d_req_i | (last_q == SrcData));
        gnt_d     = bus.d_req_i & (~fetch_req   | (last_q == SrcFetch));
        any_gnt   = gnt_i | gnt_d;
        sel_addr  = gnt_d ? bus.d_addr_i : bus.i_addr_i;
        in_win    = (sel_addr[BusWidth-1:WinLsb] == DmBaseAddress[BusWidth-1:WinLsb]);
        dm_req    = any_gnt & in_win;
    end

    // Memory-side mux; everything is zero unless an in-window grant is made
    always_comb begin
        bus.dm_req_o   = dm_req;
        bus.dm_we_o    = 1'b0;
        bus.dm_addr_o  = '0;
        bus.dm_wdata_o = '0;
        bus.dm_be_o    = '0;
        if (dm_req) begin
            bus.dm_addr_o = sel_addr;
            if (gnt_d) begin
                bus.dm_we_o    = bus.d_we_i;
                bus.dm_wdata_o = bus.d_wdata_i;
                bus.dm_be_o    = bus.d_be_i;
            end else begin
                bus.dm_be_o    = {BeWidth{1'b1}};
            end
        end
    end

    // Response routing; errors and write acks return zero data
    always_comb begin
        resp_rdata     = (resp_err_q | resp_we_q) ? '0 : bus.dm_rdata_i;
        i_rvalid       = resp_v_q & (resp_src_q == SrcFetch) & ~bus.i_flush_i;
        d_rvalid       = resp_v_q & (resp_src_q == SrcData);
        bus.i_gnt_o    = gnt_i;
        bus.d_gnt_o    = gnt_d;
        bus.i_rvalid_o = i_rvalid;
        bus.i_rdata_o  = i_rvalid ? resp_rdata : '0;
        bus.i_err_o    = i_rvalid & resp_err_q;
        bus.d_rvalid_o = d_rvalid;
        bus.d_rdata_o  = d_rvalid ? resp_rdata : '0;
        bus.d_err_o    = d_rvalid & resp_err_q;
    end

    // Round-robin history and response tracker, reloaded on every grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= SrcData;
            resp_v_q   <= 1'b0;
            resp_src_q <= SrcFetch;
            resp_err_q <= 1'b0;
            resp_we_q  <= 1'b0;
        end else if (any_gnt) begin
            last_q     <= gnt_d ? SrcData : SrcFetch;
            resp_v_q   <= 1'b1;
            resp_src_q <= gnt_d ? SrcData : SrcFetch;
            resp_err_q <= ~in_win;
            resp_we_q  <= gnt_d & bus.d_we_i;
        end else begin
            resp_v_q   <= 1'b0;
            resp_src_q <= SrcFetch;
            resp_err_q <= 1'b0;
            resp_we_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dm_mem_bus_arbiter.sv
// Self-checking bench for dm_mem_bus_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_dm_mem_bus_arbiter;
    localparam int unsigned BW      = 32;
    localparam logic [31:0] DM_BASE = 32'h0;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   errors = 0;
    int   checks = 0;

    dm_mem_bus_arbiter_if #(.BusWidth(BW)) bus ();

    dm_mem_bus_arbiter #(.BusWidth(BW), .DmBaseAddress(DM_BASE)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: who was served last and the response owed next cycle
    int   m_last;          // 0 = fetch, 1 = data
    bit   m_pend;
    int   m_src;
    bit   m_err;
    bit   m_we;
    bit   e_gi, e_gd;      // grants predicted for the current cycle

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, " i_gnt"},    bus.i_gnt_o,    1'b0);
        chk1({tag, " i_rvalid"}, bus.i_rvalid_o, 1'b0);
        chk ({tag, " i_rdata"},  bus.i_rdata_o,  32'h0);
        chk1({tag, " i_err"},    bus.i_err_o,    1'b0);
        chk1({tag, " d_gnt"},    bus.d_gnt_o,    1'b0);
        chk1({tag, " d_rvalid"}, bus.d_rvalid_o, 1'b0);
        chk ({tag, " d_rdata"},  bus.d_rdata_o,  32'h0);
        chk1({tag, " d_err"},    bus.d_err_o,    1'b0);
        chk1({tag, " dm_req"},   bus.dm_req_o,   1'b0);
        chk1({tag, " dm_we"},    bus.dm_we_o,    1'b0);
        chk ({tag, " dm_addr"},  bus.dm_addr_o,  32'h0);
        chk ({tag, " dm_wdata"}, bus.dm_wdata_o, 32'h0);
        chk4({tag, " dm_be"},    bus.dm_be_o,    4'h0);
    endtask

    task automatic drive_idle();
        bus.i_req_i    = 1'b0;
        bus.i_addr_i   = '0;
        bus.i_flush_i  = 1'b0;
        bus.d_req_i    = 1'b0;
        bus.d_we_i     = 1'b0;
        bus.d_addr_i   = '0;
        bus.d_wdata_i  = '0;
        bus.d_be_i     = '0;
        bus.dm_rdata_i = '0;
    endtask

    task automatic model_reset();
        m_last = 1;
        m_pend = 1'b0;
        m_src  = 0;
        m_err  = 1'b0;
        m_we   = 1'b0;
    endtask

    // One bus cycle: drive inputs after the edge, compare against the model, advance the model
    task automatic cycle(input string tag,
                         input logic ir, input logic [31:0] ia, input logic fl,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] dbe,
                         input logic [31:0] rd);
        logic [31:0] addr;
        bit          win;
        bit          fetch_wants;
        bit          exp_irv, exp_drv;
        logic [31:0] resp_data;
        @(posedge clk_i);
        #1;
        bus.i_req_i    = ir;
        bus.i_addr_i   = ia;
        bus.i_flush_i  = fl;
        bus.d_req_i    = dr;
        bus.d_we_i     = dw;
        bus.d_addr_i   = da;
        bus.d_wdata_i  = dwd;
        bus.d_be_i     = dbe;
        bus.dm_rdata_i = rd;
        #1;

        // Who gets served: a flushed fetch never competes; on contention the
        // master that was not served last wins.
        fetch_wants = ir && !fl;
        e_gi = 1'b0;
        e_gd = 1'b0;
        if (fetch_wants && dr) begin
            if (m_last == 1) e_gi = 1'b1;
            else             e_gd = 1'b1;
        end else begin
            e_gi = fetch_wants;
            e_gd = dr;
        end
        addr = e_gd ? da : ia;
        win  = ((addr >> 12) == (DM_BASE >> 12));

        chk1({tag, " i_gnt"}, bus.i_gnt_o, e_gi);
        chk1({tag, " d_gnt"}, bus.d_gnt_o, e_gd);
        if ((e_gi || e_gd) && win) begin
            chk1({tag, " dm_req"},   bus.dm_req_o,   1'b1);
            chk1({tag, " dm_we"},    bus.dm_we_o,    e_gd ? dw : 1'b0);
            chk ({tag, " dm_addr"},  bus.dm_addr_o,  addr);
            chk ({tag, " dm_wdata"}, bus.dm_wdata_o, e_gd ? dwd : 32'h0);
            chk4({tag, " dm_be"},    bus.dm_be_o,    e_gd ? dbe : 4'hF);
        end else begin
            chk1({tag, " dm_req"},   bus.dm_req_o,   1'b0);
            chk1({tag, " dm_we"},    bus.dm_we_o,    1'b0);
            if (!(e_gi || e_gd)) begin
                chk ({tag, " dm_addr"},  bus.dm_addr_o,  32'h0);
                chk ({tag, " dm_wdata"}, bus.dm_wdata_o, 32'h0);
                chk4({tag, " dm_be"},    bus.dm_be_o,    4'h0);
            end
        end

        // Response owed from last cycle's grant
        exp_irv   = m_pend && (m_src == 0) && !fl;
        exp_drv   = m_pend && (m_src == 1);
        resp_data = (m_err || m_we) ? 32'h0 : rd;
        chk1({tag, " i_rvalid"}, bus.i_rvalid_o, exp_irv);
        chk ({tag, " i_rdata"},  bus.i_rdata_o,  exp_irv ? resp_data : 32'h0);
        chk1({tag, " i_err"},    bus.i_err_o,    exp_irv && m_err);
        chk1({tag, " d_rvalid"}, bus.d_rvalid_o, exp_drv);
        chk ({tag, " d_rdata"},  bus.d_rdata_o,  exp_drv ? resp_data : 32'h0);
        chk1({tag, " d_err"},    bus.d_err_o,    exp_drv && m_err);

        if (e_gi || e_gd) begin
            m_pend = 1'b1;
            m_src  = e_gd ? 1 : 0;
            m_err  = !win;
            m_we   = e_gd && dw;
            m_last = m_src;
        end else begin
            m_pend = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0)
            return DM_BASE + 32'h1000 * 32'($urandom_range(1, 1000)) + 32'($urandom_range(0, 4095));
        return DM_BASE + 32'($urandom_range(0, 4095));
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic        ir, fl, dr, dw;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dbe;
        logic [1:0]  gpat [4];

        rst_ni = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single in-window fetch, response one cycle later
        cycle("fetch_req", 1, DM_BASE + 32'h800, 0, 0, 0, 0, 0, 0, 32'h0);
        chk4("fetch be", bus.dm_be_o, 4'hF);
        cycle("fetch_rsp", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0ff0000f);
        chk("fetch rdata", bus.i_rdata_o, 32'h0ff0000f);

        // Store, acked with zero data
        cycle("store_req", 0, 0, 0, 1, 1, 32'h100, 32'h0, 4'h1, 32'h0);
        chk("store dm_addr", bus.dm_addr_o, 32'h100);
        cycle("store_rsp", 0, 0, 0, 0, 0, 0, 0, 0, 32'hdeadbeef);
        chk1("store ack", bus.d_rvalid_o, 1'b1);

        // Out-of-window load: granted, no memory strobe, error response
        cycle("oow_req", 0, 0, 0, 1, 0, DM_BASE + 32'h1000, 0, 4'hF, 32'h0);
        cycle("oow_rsp", 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
        chk1("oow err", bus.d_err_o, 1'b1);

        // Fetch flushed in its response cycle while the data port requests
        cycle("flush_req", 1, DM_BASE + 32'h10, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle("flush_rsp", 1, DM_BASE + 32'h20, 1, 1, 0, DM_BASE + 32'h30, 0, 4'hF, 32'haaaa5555);
        chk1("flush suppress", bus.i_rvalid_o, 1'b0);
        chk1("flush d_gnt", bus.d_gnt_o, 1'b1);
        cycle("flush_d_rsp", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0bad0bad);
        chk1("flush d_rvalid", bus.d_rvalid_o, 1'b1);

        // Reset right after a grant: the pending response is dropped
        cycle("rst_grant", 1, DM_BASE + 32'h40, 0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk_i);
        #1;
        drive_idle();
        bus.dm_rdata_i = 32'hcafef00d;
        rst_ni = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111);

        // Both masters requesting continuously from reset: fetch, data, fetch, data
        gpat[0] = 2'b10; gpat[1] = 2'b01; gpat[2] = 2'b10; gpat[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            cycle("alternate", 1, DM_BASE + 32'h200, 0, 1, 0, DM_BASE + 32'h300, 0, 4'hF,
                  $urandom);
            chk4("alternate pattern", {2'b00, bus.i_gnt_o, bus.d_gnt_o}, {2'b00, gpat[k]});
        end
        cycle("alternate_tail", 0, 0, 0, 0, 0, 0, 0, 0, $urandom);

        // Random traffic; requests are held with stable payload until granted
        ir = 0; dr = 0; ia = 0; da = 0; dw = 0; dwd = 0; dbe = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ir) begin
                ir = ($urandom_range(0, 2) != 0);
                ia = rand_addr();
            end
            if (!dr) begin
                dr  = ($urandom_range(0, 2) != 0);
                dw  = $urandom_range(0, 1) != 0;
                da  = rand_addr();
                dwd = $urandom;
                dbe = 4'($urandom_range(0, 15));
            end
            fl = ($urandom_range(0, 5) == 0);
            cycle("random", ir, ia, fl, dr, dw, da, dwd, dbe, $urandom);
            if (e_gi) ir = 0;
            if (e_gd) dr = 0;
        end

        @(posedge clk_i);
        #1;
        drive_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
